// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - parametrised multi-port register file with write-first bypass and busy scoreboard
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       sb_set_en,
    input  logic [ADDR_W-1:0]          sb_set_addr,
    output logic                       busy_any
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs     [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W-1:0] rd_a     [NUM_RD];
    logic [DATA_W-1:0] fwd_data [NUM_RD];
    logic [NUM_RD-1:0] fwd_busy;

    // Unpack the flat read-address bus into one address per port.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_addr
        assign rd_a[p] = rd_addr[p*ADDR_W +: ADDR_W];
    end

    // Next busy state: a retiring write clears, a new issue sets, and set wins on collision.
    always_comb begin
        busy_next = busy;
        for (int j = 0; j < DEPTH; j++) begin
            if ((wr0_en && wr0_addr == ADDR_W'(j)) || (wr1_en && wr1_addr == ADDR_W'(j)))
                busy_next[j] = 1'b0;
            if (sb_set_en && sb_set_addr == ADDR_W'(j))
                busy_next[j] = 1'b1;
            if (ZERO_REG != 0 && j == 0)
                busy_next[j] = 1'b0;
        end
    end

    // Write-first read mux: wr1 beats wr0 beats the stored value; r0 is hardwired when enabled.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            if (ZERO_REG != 0 && rd_a[p] == '0)
                fwd_data[p] = '0;
            else if (wr1_en && wr1_addr == rd_a[p])
                fwd_data[p] = wr1_data;
            else if (wr0_en && wr0_addr == rd_a[p])
                fwd_data[p] = wr0_data;
            else
                fwd_data[p] = regs[rd_a[p]];
            fwd_busy[p] = busy_next[rd_a[p]];
        end
    end

    // Register array update; wr1 overrides wr0 on the same address, r0 writes dropped when hardwired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++)
                regs[j] <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (!(ZERO_REG != 0 && j == 0)) begin
                    if (wr1_en && wr1_addr == ADDR_W'(j))
                        regs[j] <= wr1_data;
                    else if (wr0_en && wr0_addr == ADDR_W'(j))
                        regs[j] <= wr0_data;
                end
            end
        end
    end

    // Scoreboard state and its summary flag, both reflecting the post-edge busy set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_any <= 1'b0;
        end else begin
            busy     <= busy_next;
            busy_any <= |busy_next;
        end
    end

    // Registered read outputs, one slice per port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++)
                rd_data[p*DATA_W +: DATA_W] <= fwd_data[p];
            rd_busy <= fwd_busy;
        end
    end

endmodule
